// File: rtl/put_data_pkg.sv
// Shared constants for the put_data APB read-out FIFO: STATUS field positions
// and default geometry.
package put_data_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 32;

  localparam int COUNT_LSB = 0;
  localparam int COUNT_W   = 5;
  localparam int EMPTY_BIT = 8;
  localparam int FULL_BIT  = 9;
  localparam int OVF_BIT   = 10;
  localparam int UNF_BIT   = 11;

  function automatic int addr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/put_data_if.sv
// Bus bundle for put_data: APB read side, fabric push side and FIFO flags.
interface put_data_if #(
  parameter int WIDTH = 32
);

  logic             read_en0;
  logic             right_addr;
  logic             status_sel;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             full;
  logic             empty;

  modport master (
    output read_en0, right_addr, status_sel, push, push_data,
    input  prdata, pready, full, empty
  );

  modport slave (
    input  read_en0, right_addr, status_sel, push, push_data,
    output prdata, pready, full, empty
  );

endinterface

// File: rtl/put_data_event_fifo.sv
// Circular word store with wrapping pointers and an explicit occupancy count.
// Storage is never cleared; reset only empties it logically.
module event_fifo
  import put_data_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int AW = addr_bits(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a push while full is still legal.
  assign do_wr = wr_en & (~full | do_rd);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !res) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/put_data.sv
// APB-readable event FIFO: DATA register pops the head, STATUS register reports
// count/flags and clears the sticky overflow/underflow bits on read.
module put_data
  import put_data_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       res,
  put_data_if.slave  bus
);

  localparam int CW = addr_bits(DEPTH) + 1;

  logic             rd;
  logic             data_rd;
  logic             stat_rd;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] status_w;
  logic [WIDTH-1:0] prdata;

  assign rd      = bus.read_en0 & bus.right_addr;
  assign data_rd = rd & ~bus.status_sel;
  assign stat_rd = rd & bus.status_sel;
  assign pop     = data_rd & ~empty;
  assign ovf_set = bus.push & full & ~pop;
  assign unf_set = data_rd & empty;

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .res     (res),
    .wr_en   (bus.push),
    .rd_en   (data_rd),
    .wr_data (bus.push_data),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // A new event in the same cycle as a STATUS read keeps its flag set.
  always_ff @(posedge clk) begin
    if (res) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~stat_rd);
      underflow <= unf_set | (underflow & ~stat_rd);
    end
  end

  always_comb begin
    status_w                   = '0;
    status_w[COUNT_LSB +: CW]  = count;
    status_w[EMPTY_BIT]        = empty;
    status_w[FULL_BIT]         = full;
    status_w[OVF_BIT]          = overflow;
    status_w[UNF_BIT]          = underflow;
  end

  always_comb begin
    prdata = '0;
    if (data_rd && !empty) prdata = head;
    else if (stat_rd)      prdata = status_w;
  end

  assign bus.prdata = prdata;
  assign bus.pready = 1'b1;
  assign bus.full   = full;
  assign bus.empty  = empty;

endmodule
